// File: rtl/forward_data_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the multi-channel toggle-handshake receiver.
package forward_data_pkg;

   // A single flop cannot resolve metastability, so the req synchroniser needs at least two stages.
   localparam int MIN_SYNC_STAGES = 2;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // Channel index width; a single-channel build still gets a one-bit index.
   function automatic int ch_width(input int n_channels);
      return (clog2(n_channels) < 1) ? 1 : clog2(n_channels);
   endfunction

endpackage

// File: rtl/forward_data_mux_arbiter.sv
`timescale 1ns/1ps
// Combinational round-robin arbiter: the search starts at the channel after the last grant.
// The last-grant pointer register is owned by the parent.
module round_robin_arbiter
   import forward_data_pkg::*;
#(
   parameter  int N  = 4,
   localparam int CW = ch_width(N)
) (
   input  logic [N-1:0]  request,
   input  logic [CW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [CW-1:0] grant_index,
   output logic          any_request
);

   // Walk the rotation from farthest to nearest so the nearest requester after last_grant is the one left standing.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_index = '0;
      any_request = |request;
      for (int offset = N; offset >= 1; offset--) begin
         idx = (int'(last_grant) + offset) % N;
         if (request[idx]) begin
            grant       = '0;
            grant[idx]  = 1'b1;
            grant_index = CW'(idx);
         end
      end
   end

endmodule

// File: rtl/forward_data_mux.sv
`timescale 1ns/1ps
// Receive side of an N-channel toggle-handshake forwarder. Each producer's req toggle is
// synchronised, pending words are captured round-robin into one valid/ready stream tagged
// with the channel index, and the ack toggle for a channel flips at the moment of capture.
module forward_data_mux
   import forward_data_pkg::*;
#(
   parameter  int N_CHANNELS  = 4,
   parameter  int DATA_WIDTH  = 32,
   parameter  int SYNC_STAGES = 2,
   localparam int CH_WIDTH    = ch_width(N_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic [N_CHANNELS-1:0]            inReq,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0] inData,
   output logic [N_CHANNELS-1:0]            inAck,
   output logic                             outValid,
   input  logic                             outReady,
   output logic [DATA_WIDTH-1:0]            outData,
   output logic [CH_WIDTH-1:0]              outChannel,
   output logic [N_CHANNELS-1:0]            pending
);

   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
      $error("forward_data_mux: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
   end

   logic [N_CHANNELS-1:0] req_sync;
   logic [DATA_WIDTH-1:0] words [N_CHANNELS];
   logic [CH_WIDTH-1:0]   last_grant;
   logic [N_CHANNELS-1:0] grant;
   logic [CH_WIDTH-1:0]   grant_index;
   logic                  any_pending;
   logic                  load;

   for (genvar i = 0; i < N_CHANNELS; i++) begin : g_channel
      (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_stages;

      // Bring the asynchronous req toggle into the clk domain through a plain shift chain.
      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            sync_stages <= '0;
         end else begin
            sync_stages <= {sync_stages[SYNC_STAGES-2:0], inReq[i]};
         end
      end

      assign req_sync[i] = sync_stages[SYNC_STAGES-1];

      // Data is never synchronised: it is only sampled while this channel is pending, when the producer holds it.
      assign words[i] = inData[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Built only from registered state, so the arbiter never sees a glitching request.
   assign pending = req_sync ^ inAck;

   round_robin_arbiter #(
      .N (N_CHANNELS)
   ) u_arbiter (
      .request     (pending),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_index (grant_index),
      .any_request (any_pending)
   );

   // A new word may enter whenever the output register is empty or being drained this edge.
   assign load = any_pending && (!outValid || outReady);

   // Output register, ack toggles and fairness pointer; a load on the same edge as a consume replaces the word.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         inAck      <= '0;
         outValid   <= 1'b0;
         outData    <= '0;
         outChannel <= '0;
         last_grant <= CH_WIDTH'(N_CHANNELS - 1);
      end else if (load) begin
         outData    <= words[grant_index];
         outChannel <= grant_index;
         outValid   <= 1'b1;
         inAck      <= inAck ^ grant;
         last_grant <= grant_index;
      end else if (outValid && outReady) begin
         outValid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_forward_data_mux.sv
`timescale 1ns/1ps
// Self-checking bench for forward_data_mux: directed handshake scenarios followed by a
// randomised multi-clock run scored against per-channel expected word sequences.
module tb_forward_data_mux;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int SS    = 2;
   localparam int WORDS = 300;

   logic            clk = 1'b0;
   logic            resetN;
   logic [N-1:0]    inReq;
   logic [N*DW-1:0] inData;
   logic [N-1:0]    inAck;
   logic            outValid;
   logic            outReady;
   logic [DW-1:0]   outData;
   logic [1:0]      outChannel;
   logic [N-1:0]    pending;

   logic            cdc_mode  = 1'b0;
   logic            cdc_start = 1'b0;
   logic [DW-1:0]   seed      = '0;

   logic            dir_req  [N];
   logic [DW-1:0]   dir_data [N];
   logic            cdc_req  [N];
   logic [DW-1:0]   cdc_data [N];

   int compared   = 0;
   int mismatched = 0;

   forward_data_mux #(
      .N_CHANNELS  (N),
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .inReq      (inReq),
      .inData     (inData),
      .inAck      (inAck),
      .outValid   (outValid),
      .outReady   (outReady),
      .outData    (outData),
      .outChannel (outChannel),
      .pending    (pending)
   );

   // 100 MHz consumer-side clock.
   always #5 clk = ~clk;

   // Producer lines come from the directed sequence or from the free-running producers.
   always_comb begin
      inReq  = '0;
      inData = '0;
      for (int i = 0; i < N; i++) begin
         inReq[i]            = cdc_mode ? cdc_req[i]  : dir_req[i];
         inData[i*DW +: DW]  = cdc_mode ? cdc_data[i] : dir_data[i];
      end
   end

   // Expected content of word w on channel ch during the random run.
   function automatic logic [DW-1:0] word_value(input int ch, input int w);
      return seed ^ (32'(w) * 32'h9E3779B1) ^ (32'(ch) << 28) ^ 32'(ch * 7919);
   endfunction

   // Independent producers, each on its own clock (periods 3.7 ns .. 31 ns against 10 ns).
   for (genvar p = 0; p < N; p++) begin : g_prod
      localparam real HALF = (p == 0) ? 1.85 : (p == 1) ? 7.3 : (p == 2) ? 15.5 : 11.1;
      logic          pclk   = 1'b0;
      logic          ack_s1 = 1'b0;
      logic          ack_s2 = 1'b0;
      logic          req_l  = 1'b0;
      logic [DW-1:0] data_l = '0;

      assign cdc_req[p]  = req_l;
      assign cdc_data[p] = data_l;

      always #(HALF) pclk = ~pclk;

      // Producer-side synchroniser for the returning ack toggle.
      always @(posedge pclk) begin
         ack_s1 <= inAck[p];
         ack_s2 <= ack_s1;
      end

      initial begin
         int budget;
         wait (cdc_start);
         for (int w = 0; w < WORDS; w++) begin
            repeat ($urandom_range(0, 3)) @(posedge pclk);
            @(posedge pclk);
            data_l = word_value(p, w);
            req_l  = ~req_l;
            budget = 0;
            while (ack_s2 !== req_l && budget < 5000) begin
               @(posedge pclk);
               budget++;
            end
            if (ack_s2 !== req_l) break;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_reset();
      resetN = 1'b0;
      for (int i = 0; i < N; i++) dir_req[i] = 1'b0;
      tick(2);
      resetN = 1'b1;
      tick(1);
   endtask

   initial begin
      int            rx_count [N];
      int            rx_total;
      int            budget;
      int            loads;
      logic          counting;
      logic          served;
      logic [N-1:0]  prev_ack;

      resetN   = 1'b0;
      outReady = 1'b0;
      for (int i = 0; i < N; i++) begin
         dir_req[i]  = 1'b0;
         dir_data[i] = '0;
         rx_count[i] = 0;
      end
      tick(3);

      // Reset state.
      check_output("rst_outValid",   outValid,   0);
      check_output("rst_inAck",      inAck,      0);
      check_output("rst_outData",    outData,    0);
      check_output("rst_outChannel", outChannel, 0);
      check_output("rst_pending",    pending,    0);
      resetN = 1'b1;
      tick(1);

      // Single toggle on channel 2: visible after two sync edges, captured on the third.
      outReady    = 1'b1;
      dir_data[2] = 32'hDEADBEEF;
      dir_req[2]  = 1'b1;
      tick(1);
      check_output("t1_valid_edge_k", outValid, 0);
      tick(1);
      check_output("t1_valid_edge_k1",   outValid, 0);
      check_output("t1_pending_edge_k1", pending,  4'b0100);
      tick(1);
      check_output("t1_valid",   outValid,   1);
      check_output("t1_data",    outData,    32'hDEADBEEF);
      check_output("t1_channel", outChannel, 2);
      check_output("t1_ack",     inAck,      4'b0100);
      check_output("t1_pending", pending,    0);
      tick(1);
      check_output("t1_drained", outValid, 0);

      // All channels at once from a fresh reset: served 0,1,2,3 back to back.
      apply_reset();
      for (int i = 0; i < N; i++) begin
         dir_data[i] = 32'h10 + 32'(i);
         dir_req[i]  = 1'b1;
      end
      tick(2);
      for (int b = 0; b < N; b++) begin
         tick(1);
         check_output("t2_valid",   outValid,   1);
         check_output("t2_channel", outChannel, b);
         check_output("t2_data",    outData,    32'h10 + 32'(b));
      end
      tick(1);
      check_output("t2_drained", outValid, 0);
      check_output("t2_ack",     inAck,    4'b1111);
      check_output("t2_pending", pending,  0);

      // Backpressure: a held word must not move while another channel waits.
      outReady    = 1'b0;
      dir_data[1] = 32'hA1;
      dir_req[1]  = ~dir_req[1];
      tick(3);
      check_output("t3_loaded_valid",   outValid,   1);
      check_output("t3_loaded_channel", outChannel, 1);
      dir_data[3] = 32'h33;
      dir_req[3]  = ~dir_req[3];
      tick(4);
      check_output("t3_hold_valid",   outValid,   1);
      check_output("t3_hold_data",    outData,    32'hA1);
      check_output("t3_hold_channel", outChannel, 1);
      check_output("t3_hold_ack3",    inAck[3],   1);
      check_output("t3_pending3",     pending,    4'b1000);
      outReady = 1'b1;
      tick(1);
      check_output("t3_swap_valid",   outValid,   1);
      check_output("t3_swap_channel", outChannel, 3);
      check_output("t3_swap_data",    outData,    32'h33);
      check_output("t3_swap_ack3",    inAck[3],   0);
      tick(1);
      check_output("t3_drained", outValid, 0);

      // Fairness: channel 0 hammers, channel 1 asks once and must be served within two loads.
      served   = 1'b0;
      counting = 1'b0;
      loads    = 0;
      prev_ack = inAck;
      for (int c = 0; c < 40 && !served; c++) begin
         if (c == 4) begin
            dir_data[1] = 32'hC1;
            dir_req[1]  = ~dir_req[1];
         end
         if (dir_req[0] == inAck[0]) begin
            dir_data[0] = $urandom;
            dir_req[0]  = ~dir_req[0];
         end
         tick(1);
         if (counting) loads += $countones(inAck ^ prev_ack);
         if (inAck[1] != prev_ack[1]) begin
            served = 1'b1;
            check_output("t4_ch1_channel",    outChannel, 1);
            check_output("t4_ch1_data",       outData,    32'hC1);
            check_output("t4_ch1_wait_loads", loads <= 2, 1);
         end
         if (pending[1]) counting = 1'b1;
         prev_ack = inAck;
      end
      check_output("t4_ch1_served", served, 1);
      tick(8);
      check_output("t4_drained_valid",   outValid, 0);
      check_output("t4_drained_pending", pending,  0);

      // Reset in the middle of a transfer discards the held word and clears every ack.
      outReady    = 1'b0;
      dir_data[1] = 32'h51;
      dir_req[1]  = ~dir_req[1];
      tick(3);
      check_output("t5_pre_valid", outValid, 1);
      dir_data[2] = 32'h52;
      dir_req[2]  = ~dir_req[2];
      tick(3);
      check_output("t5_pre_pending2", pending[2], 1);
      resetN = 1'b0;
      for (int i = 0; i < N; i++) dir_req[i] = 1'b0;
      #1;
      check_output("t5_async_valid", outValid, 0);
      check_output("t5_async_ack",   inAck,    0);
      check_output("t5_async_data",  outData,  0);
      tick(2);
      resetN = 1'b1;
      tick(6);
      check_output("t5_after_valid",   outValid, 0);
      check_output("t5_after_pending", pending,  0);
      check_output("t5_after_ack",     inAck,    0);

      // Random multi-clock run: every channel's words must arrive in order, exactly once.
      seed      = $urandom;
      cdc_mode  = 1'b1;
      cdc_start = 1'b1;
      rx_total  = 0;
      budget    = 0;
      while (rx_total < N * WORDS && budget < 60000) begin
         tick(1);
         budget++;
         outReady = 1'($urandom_range(0, 1));
         if (outValid && outReady) begin
            check_output("cdc_data", outData, word_value(int'(outChannel), rx_count[outChannel]));
            rx_count[outChannel]++;
            rx_total++;
         end
      end
      check_output("cdc_all_words_within_budget", rx_total, N * WORDS);
      outReady = 1'b1;
      tick(20);
      check_output("cdc_final_valid",   outValid, 0);
      check_output("cdc_final_pending", pending,  0);
      for (int i = 0; i < N; i++) begin
         check_output("cdc_channel_count", rx_count[i], WORDS);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
